// File: rtl/window_sorter_if.sv
// Command/register-port bundle between the sort controller and window_sorter.
interface window_sorter_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int MAXC  = 6
) ();
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAXC + 1);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             start;
  logic [AW-1:0]    src;
  logic [AW-1:0]    dst;
  logic [CW-1:0]    count;
  logic             desc;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, start, src, dst, count, desc,
    input  rd_data, busy, done, err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, start, src, dst, count, desc,
    output rd_data, busy, done, err
  );
endinterface

// File: rtl/window_sorter.sv
// Register-window sorter: copies a window of the register file into a private
// buffer, sorts it with an odd-even transposition network (one pass per
// cycle), and writes it back to a destination window.

// One compare-exchange lane of the transposition network.
module window_sorter_cmpx #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         en,
  input  logic         desc,
  output logic         swap
);
  assign swap = en & (desc ? (a < b) : (a > b));
endmodule

module window_sorter #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int MAXC  = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  window_sorter_if.slave bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(MAXC + 1);
  localparam int AW1 = AW + 1;
  // Range checks are done wide enough that neither operand nor sum wraps.
  localparam int SW  = ((AW > CW) ? AW : CW) + 1;
  localparam logic [SW-1:0]  DEPTH_S = SW'(DEPTH);
  localparam logic [SW-1:0]  MAXC_S  = SW'(MAXC);
  localparam logic [AW1-1:0] DEPTH_A = AW1'(DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, SORT, STORE, DONE} state_e;

  state_e                       state_q, state_d;
  logic [CW-1:0]                k_q, k_d;
  logic [AW-1:0]                src_q, dst_q;
  logic [CW-1:0]                cnt_q;
  logic                         desc_q, rej_q;
  logic [DEPTH-1:0][WIDTH-1:0]  rf;
  logic [MAXC-1:0][WIDTH-1:0]   sbuf, sbuf_nxt;
  logic [MAXC-2:0]              swap;
  logic [SW-1:0]                src_end, dst_end;
  logic                         reject, last;
  logic [AW-1:0]                rd_ptr, wr_ptr;

  assign src_end = SW'(bus.src) + SW'(bus.count);
  assign dst_end = SW'(bus.dst) + SW'(bus.count);
  assign reject  = (bus.count == '0) || (SW'(bus.count) > MAXC_S) ||
                   (src_end > DEPTH_S) || (dst_end > DEPTH_S);

  // k doubles as LOAD/STORE index and SORT pass number.
  assign last   = (k_q == cnt_q - CW'(1));
  assign rd_ptr = src_q + AW'(k_q);
  assign wr_ptr = dst_q + AW'(k_q);

  assign bus.rd_data = ({1'b0, bus.rd_addr} < DEPTH_A) ? rf[bus.rd_addr] : '0;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.err     = (state_q == DONE) && rej_q;

  // One lane per adjacent pair; only lanes matching the pass parity and
  // lying fully inside the window may swap.
  for (genvar i = 0; i < MAXC - 1; i++) begin : g_lane
    localparam logic          PAR = 1'(i % 2);
    localparam logic [CW-1:0] HI  = CW'(i + 1);
    logic en;
    assign en = (state_q == SORT) && (k_q[0] == PAR) && (HI < cnt_q);
    window_sorter_cmpx #(.W(WIDTH)) u_cmpx (
      .a    (sbuf[i]),
      .b    (sbuf[i+1]),
      .en   (en),
      .desc (desc_q),
      .swap (swap[i])
    );
  end

  // Apply one transposition pass; active pairs in a pass are disjoint.
  always_comb begin
    sbuf_nxt = sbuf;
    for (int i = 0; i < MAXC - 1; i++) begin
      if (swap[i]) begin
        sbuf_nxt[i]   = sbuf[i+1];
        sbuf_nxt[i+1] = sbuf[i];
      end
    end
  end

  // State and step-counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Next-state: each working phase lasts exactly count cycles.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          k_d     = '0;
          state_d = reject ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (last) begin
          k_d     = '0;
          state_d = SORT;
        end else begin
          k_d = k_q + CW'(1);
        end
      end
      SORT: begin
        if (last) begin
          k_d     = '0;
          state_d = STORE;
        end else begin
          k_d = k_q + CW'(1);
        end
      end
      STORE: begin
        if (last) begin
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d = k_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register file, buffer and latched command; external writes only in IDLE,
  // so a write sampled with start lands before LOAD reads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf     <= '0;
      sbuf   <= '0;
      src_q  <= '0;
      dst_q  <= '0;
      cnt_q  <= '0;
      desc_q <= 1'b0;
      rej_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_A))
            rf[bus.wr_addr] <= bus.wr_data;
          if (bus.start) begin
            src_q  <= bus.src;
            dst_q  <= bus.dst;
            cnt_q  <= bus.count;
            desc_q <= bus.desc;
            rej_q  <= reject;
          end
        end
        LOAD:    sbuf[k_q]  <= rf[rd_ptr];
        SORT:    sbuf       <= sbuf_nxt;
        STORE:   rf[wr_ptr] <= sbuf[k_q];
        default: ;
      endcase
    end
  end
endmodule
